// File: rtl/vs_sci_pkg.sv
// -----------------------------------------------------------------------------
// vs_sci_pkg
// Shared definitions for the VS10xx SCI command sequencer: FSM state encoding,
// SCI opcodes, SCI register addresses and init-table field widths.
// Optional feature macro used by importers: VS_SCI_READBACK_CHECK_EN.
// -----------------------------------------------------------------------------
package vs_sci_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GAP       = 3'd1,
    ISSUE     = 3'd2,
    WAIT_HIGH = 3'd3,
    ERR       = 3'd4
  } state_t;

  localparam logic [7:0] SCI_WR_INST = 8'h02;
  localparam logic [7:0] SCI_RD_INST = 8'h03;

  localparam logic [7:0] SCI_MODE   = 8'h00;
  localparam logic [7:0] SCI_CLOCKF = 8'h03;
  localparam logic [7:0] SCI_AUDATA = 8'h05;
  localparam logic [7:0] SCI_VOL    = 8'h0B;

  localparam int PTR_W  = 4;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

endpackage

// File: rtl/vs_sci_sequencer_rom.sv
// -----------------------------------------------------------------------------
// vs_init_rom
// Combinational init table: entry pointer -> {rdh_wrl, addr, data}.
// Ports:
//   ptr      in  PTR_W   entry index
//   rdh_wrl  out 1       1 = read entry, 0 = write entry
//   addr     out 8       SCI register address
//   data     out 8       write data
// -----------------------------------------------------------------------------
module vs_init_rom
  import vs_sci_pkg::*;
(
  input  logic [PTR_W-1:0]  ptr,
  output logic              rdh_wrl,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    rdh_wrl = 1'b0;
    // Unused slots repeat the MODE write so an oversized table stays benign.
    addr    = SCI_MODE;
    data    = 8'h08;
    case (ptr)
      4'd0: begin addr = SCI_MODE;   data = 8'h08; end
      4'd1: begin addr = SCI_CLOCKF; data = 8'h98; end
      4'd2: begin addr = SCI_AUDATA; data = 8'hAC; end
      4'd3: begin addr = SCI_VOL;    data = 8'h20; end
      default: ;
    endcase
  end

endmodule

// File: rtl/vs_sci_sequencer.sv
// -----------------------------------------------------------------------------
// vs_sci_sequencer
// Command source for the SPI transmitter feeding the VS10xx. After start it
// issues the init table as SCI writes, then serves host read/write commands.
// Completion of each frame is detected from the transmitter's CSN.
// Optional macro VS_SCI_READBACK_CHECK_EN: every init write is followed by a
// read of the same address; a data mismatch raises error.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start                       pulse: (re)start init sequence (ignored when busy)
//   busy/init_done/error        status (init_done, error sticky)
//   cmd_valid/cmd_ready         host command handshake (ready = accept pulse)
//   cmd_rdh_wrl/addr/data       host command fields
//   rsp_valid/rsp_data          host command completion pulse + read data
//   spi_ready/inst/rdh_wrl/reg_addr/dout   transmitter control outputs
//   spi_din/spi_din_valid/spi_csn          transmitter feedback
// -----------------------------------------------------------------------------
module vs_sci_sequencer
  import vs_sci_pkg::*;
#(
  parameter int         NUM_INIT       = 4,
  parameter int         GAP_CYCLES     = 50,
  parameter int         TIMEOUT_CYCLES = 2048,
  parameter logic [7:0] WR_INST        = 8'h02,
  parameter logic [7:0] RD_INST        = 8'h03
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       init_done,
  output logic       error,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rdh_wrl,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       spi_ready,
  output logic [7:0] spi_inst,
  output logic       spi_rdh_wrl,
  output logic [7:0] spi_reg_addr,
  output logic [7:0] spi_dout,
  input  logic [7:0] spi_din,
  input  logic       spi_din_valid,
  input  logic       spi_csn
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_INIT - 1);

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               host_phase;
  logic [7:0]         din_cap;
  logic [7:0]         din_now;
`ifdef VS_SCI_READBACK_CHECK_EN
  logic               verify;
`endif

  logic [PTR_W-1:0]   rom_idx;
  logic               rom_rdh_wrl;
  logic [7:0]         rom_addr;
  logic [7:0]         rom_data;

  // The single ROM port serves entry 0 on start and the next entry when a
  // frame completes; no other state needs the table.
  always_comb begin
    rom_idx = '0;
    if (state == WAIT_HIGH) rom_idx = ptr + 1'b1;
  end

  vs_init_rom u_rom (
    .ptr     (rom_idx),
    .rdh_wrl (rom_rdh_wrl),
    .addr    (rom_addr),
    .data    (rom_data)
  );

  // Read data may arrive on the same cycle CSN rises, so use it directly.
  assign din_now = spi_din_valid ? spi_din : din_cap;
  assign busy    = (state != IDLE) && (state != ERR);

  // Data capture register: cleared when a frame starts, loaded on din_valid.
  always_ff @(posedge clk) begin
    if (state == ISSUE && !spi_csn)
      din_cap <= '0;
    else if (state == WAIT_HIGH && spi_din_valid)
      din_cap <= spi_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      gap_cnt      <= '0;
      to_cnt       <= '0;
      host_phase   <= 1'b0;
      spi_ready    <= 1'b0;
      spi_inst     <= WR_INST;
      spi_rdh_wrl  <= 1'b0;
      spi_reg_addr <= '0;
      spi_dout     <= '0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      init_done    <= 1'b0;
      error        <= 1'b0;
`ifdef VS_SCI_READBACK_CHECK_EN
      verify       <= 1'b0;
`endif
    end else begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            ptr          <= '0;
            init_done    <= 1'b0;
            error        <= 1'b0;
            host_phase   <= 1'b0;
            spi_ready    <= 1'b0;
            spi_inst     <= rom_rdh_wrl ? RD_INST : WR_INST;
            spi_rdh_wrl  <= rom_rdh_wrl;
            spi_reg_addr <= rom_addr;
            spi_dout     <= rom_data;
            gap_cnt      <= '0;
`ifdef VS_SCI_READBACK_CHECK_EN
            verify       <= 1'b0;
`endif
            state        <= GAP;
          end else if (state == IDLE && init_done && cmd_valid) begin
            cmd_ready    <= 1'b1;
            host_phase   <= 1'b1;
            spi_inst     <= cmd_rdh_wrl ? RD_INST : WR_INST;
            spi_rdh_wrl  <= cmd_rdh_wrl;
            spi_reg_addr <= cmd_addr;
            spi_dout     <= cmd_data;
            gap_cnt      <= '0;
            state        <= GAP;
          end
        end

        // Enforce CSN-high time before the next ready rise; any CSN low restarts it.
        GAP: begin
          if (!spi_csn) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            spi_ready <= 1'b1;
            to_cnt    <= '0;
            state     <= ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        // Hold ready until the transmitter acknowledges by pulling CSN low.
        ISSUE: begin
          if (!spi_csn) begin
            spi_ready <= 1'b0;
            to_cnt    <= '0;
            state     <= WAIT_HIGH;
          end else if (to_cnt == TO_LAST) begin
            spi_ready <= 1'b0;
            error     <= 1'b1;
            state     <= ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        // Frame in flight; CSN rising marks completion.
        WAIT_HIGH: begin
          if (spi_csn) begin
            gap_cnt <= '0;
            if (host_phase) begin
              rsp_valid  <= 1'b1;
              rsp_data   <= spi_rdh_wrl ? din_now : 8'h00;
              host_phase <= 1'b0;
              state      <= IDLE;
            end else
`ifdef VS_SCI_READBACK_CHECK_EN
            if (!verify && !spi_rdh_wrl) begin
              // Re-read the address just written; spi_dout keeps the
              // written value for the comparison.
              verify      <= 1'b1;
              spi_inst    <= RD_INST;
              spi_rdh_wrl <= 1'b1;
              state       <= GAP;
            end else if (verify && (din_now != spi_dout)) begin
              verify <= 1'b0;
              error  <= 1'b1;
              state  <= ERR;
            end else
`endif
            begin
`ifdef VS_SCI_READBACK_CHECK_EN
              verify <= 1'b0;
`endif
              if (ptr < PTR_LAST) begin
                ptr          <= ptr + 1'b1;
                spi_inst     <= rom_rdh_wrl ? RD_INST : WR_INST;
                spi_rdh_wrl  <= rom_rdh_wrl;
                spi_reg_addr <= rom_addr;
                spi_dout     <= rom_data;
                state        <= GAP;
              end else begin
                init_done <= 1'b1;
                state     <= IDLE;
              end
            end
          end else if (to_cnt == TO_LAST) begin
            error <= 1'b1;
            state <= ERR;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vs_sci_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vs_sci_sequencer
// Bench for vs_sci_sequencer with an attached SPI transmitter model (random
// CSN timing, register memory) and a register-level reference of the host view.
// -----------------------------------------------------------------------------
module tb_vs_sci_sequencer;

  localparam int GAP = 50;
  localparam int TO  = 2048;
  localparam int NI  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, init_done, error;
  logic       cmd_valid, cmd_ready, cmd_rdh_wrl;
  logic [7:0] cmd_addr, cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       spi_ready, spi_rdh_wrl;
  logic [7:0] spi_inst, spi_reg_addr, spi_dout;
  logic [7:0] spi_din;
  logic       spi_din_valid, spi_csn;

  always #5 clk = ~clk;

  vs_sci_sequencer #(
    .NUM_INIT(NI), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO),
    .WR_INST(8'h02), .RD_INST(8'h03)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .init_done(init_done),
    .error(error), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rdh_wrl(cmd_rdh_wrl), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .spi_ready(spi_ready),
    .spi_inst(spi_inst), .spi_rdh_wrl(spi_rdh_wrl), .spi_reg_addr(spi_reg_addr),
    .spi_dout(spi_dout), .spi_din(spi_din), .spi_din_valid(spi_din_valid),
    .spi_csn(spi_csn)
  );

  // ---------------- transmitter model ----------------
  typedef struct packed {
    logic [7:0] inst;
    logic       rd;
    logic [7:0] addr;
    logic [7:0] dout;
  } frame_t;

  frame_t     fr_log [256];
  int         fr_cnt = 0;
  logic [7:0] mem [256];
  int         cyc = 0, rise_cyc = 0, gap_viol = 0;
  bit         have_rise;
  int         m_ph, m_cnt;
  logic       ready_q;
  logic       model_en;
  logic       ovr_en;
  logic [7:0] ovr_addr, ovr_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_csn       <= 1'b1;
      spi_din_valid <= 1'b0;
      spi_din       <= '0;
      m_ph          <= 0;
      m_cnt         <= 0;
      ready_q       <= 1'b0;
      have_rise     <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      cyc           <= cyc + 1;
      ready_q       <= spi_ready;
      spi_din_valid <= 1'b0;
      if (spi_ready && !ready_q && have_rise && (cyc - rise_cyc) < GAP + 1)
        gap_viol <= gap_viol + 1;
      case (m_ph)
        0: if (model_en && spi_ready) begin
             m_cnt <= $urandom_range(0, 4);
             m_ph  <= 1;
           end
        1: if (m_cnt == 0) begin
             spi_csn <= 1'b0;
             fr_log[fr_cnt & 255] <= '{spi_inst, spi_rdh_wrl, spi_reg_addr, spi_dout};
             fr_cnt <= fr_cnt + 1;
             if (!spi_rdh_wrl) mem[spi_reg_addr] <= spi_dout;
             m_cnt <= $urandom_range(3, 10);
             m_ph  <= 2;
           end else m_cnt <= m_cnt - 1;
        default: begin
          if (m_cnt == 1 && spi_rdh_wrl) begin
            spi_din_valid <= 1'b1;
            spi_din <= (ovr_en && spi_reg_addr == ovr_addr) ? ovr_val : mem[spi_reg_addr];
          end
          if (m_cnt == 0) begin
            spi_csn   <= 1'b1;
            rise_cyc  <= cyc;
            have_rise <= 1'b1;
            m_ph      <= 0;
          end else m_cnt <= m_cnt - 1;
        end
      endcase
    end
  end

  // ---------------- checking ----------------
  int checks = 0, failures = 0;
  logic [7:0] init_addr [4] = '{8'h00, 8'h03, 8'h05, 8'h0B};
  logic [7:0] init_data [4] = '{8'h08, 8'h98, 8'hAC, 8'h20};
  logic [7:0] ref_regs [256];

  typedef struct {
    bit         rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " spi_ready"}, spi_ready, 0);
    chk({tag, " spi_inst"}, spi_inst, 8'h02);
    chk({tag, " spi_rdh_wrl"}, spi_rdh_wrl, 0);
    chk({tag, " spi_reg_addr"}, spi_reg_addr, 0);
    chk({tag, " spi_dout"}, spi_dout, 0);
    chk({tag, " cmd_ready"}, cmd_ready, 0);
    chk({tag, " rsp_valid"}, rsp_valid, 0);
    chk({tag, " rsp_data"}, rsp_data, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " init_done"}, init_done, 0);
    chk({tag, " error"}, error, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_flags(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (init_done || error) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_frame(input int idx, input logic [7:0] inst, input logic rd,
                             input logic [7:0] addr, input logic [7:0] dout,
                             input string tag);
    frame_t f;
    f = fr_log[idx & 255];
    chk($sformatf("%s frame%0d inst", tag, idx), f.inst, inst);
    chk($sformatf("%s frame%0d rdh_wrl", tag, idx), f.rd, rd);
    chk($sformatf("%s frame%0d addr", tag, idx), f.addr, addr);
    if (!rd) chk($sformatf("%s frame%0d dout", tag, idx), f.dout, dout);
  endtask

  task automatic check_init_frames(input int base, input string tag);
    int k = 0;
    for (int i = 0; i < NI; i++) begin
      check_frame(base + k, 8'h02, 1'b0, init_addr[i], init_data[i], tag);
      k++;
`ifdef VS_SCI_READBACK_CHECK_EN
      check_frame(base + k, 8'h03, 1'b1, init_addr[i], 8'h00, tag);
      k++;
`endif
    end
    chk({tag, " frame count"}, fr_cnt - base, k);
  endtask

  task automatic finish_init_checks(input int base, input int gv0, input string tag);
    bit ok;
    wait_flags(6000, ok);
    chk({tag, " completes in budget"}, ok, 1);
    chk({tag, " init_done"}, init_done, 1);
    chk({tag, " error"}, error, 0);
    chk({tag, " busy after"}, busy, 0);
    check_init_frames(base, tag);
    chk({tag, " ready spacing violations"}, gap_viol - gv0, 0);
    for (int i = 0; i < 256; i++) ref_regs[i] = 8'h00;
    for (int i = 0; i < NI; i++) ref_regs[init_addr[i]] = init_data[i];
  endtask

  task automatic host_cmd(input bit rd, input logic [7:0] addr, input logic [7:0] data,
                          output logic [7:0] rsp, output bit ok);
    bit acc = 1'b0;
    ok = 1'b0;
    rsp = 8'hxx;
    cmd_valid = 1'b1; cmd_rdh_wrl = rd; cmd_addr = addr; cmd_data = data;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin acc = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    if (acc) begin
      for (int i = 0; i < 2000; i++) begin
        @(negedge clk);
        if (rsp_valid) begin ok = 1'b1; rsp = rsp_data; break; end
      end
    end
  endtask

  initial begin
    int base, gv0, n, cr_cnt, extra;
    bit ok;
    logic [7:0] rsp, exp;
    bit rd;
    logic [7:0] a, d;

    vecs[0] = '{1'b1, 8'h0B, 8'h00, 8'h20};
    vecs[1] = '{1'b1, 8'h03, 8'h00, 8'h98};
    vecs[2] = '{1'b0, 8'h0B, 8'h33, 8'h00};
    vecs[3] = '{1'b1, 8'h0B, 8'h00, 8'h33};
    vecs[4] = '{1'b0, 8'h05, 8'h7E, 8'h00};
    vecs[5] = '{1'b1, 8'h05, 8'h00, 8'h7E};
    vecs[6] = '{1'b1, 8'h00, 8'h00, 8'h08};

    rst = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_rdh_wrl = 1'b0;
    cmd_addr = '0; cmd_data = '0; model_en = 1'b1;
    ovr_en = 1'b0; ovr_addr = '0; ovr_val = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // host requests before init and while busy must not be accepted
    cr_cnt = 0;
    cmd_valid = 1'b1; cmd_rdh_wrl = 1'b0; cmd_addr = 8'h0B; cmd_data = 8'h11;
    repeat (20) begin @(negedge clk); if (cmd_ready) cr_cnt++; end
    base = fr_cnt; gv0 = gap_viol;
    pulse_start();
    chk("busy after start", busy, 1);
    for (int i = 0; i < 6000 && !init_done && !error; i++) begin
      if (i == 30 || i == 150) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (cmd_ready) cr_cnt++;
    end
    cmd_valid = 1'b0;
    chk("cmd_ready before init_done", cr_cnt, 0);
    finish_init_checks(base, gv0, "init1");

    // table-driven host commands
    for (int i = 0; i < 7; i++) begin
      host_cmd(vecs[i].rd, vecs[i].addr, vecs[i].data, rsp, ok);
      chk($sformatf("vec%0d handshake", i), ok, 1);
      chk($sformatf("vec%0d rsp_data", i), rsp, vecs[i].exp);
      if (!vecs[i].rd) ref_regs[vecs[i].addr] = vecs[i].data;
    end

    // read of VOL with the transmitter returning 8'h5A, exactly one response
    ovr_en = 1'b1; ovr_addr = 8'h0B; ovr_val = 8'h5A;
    host_cmd(1'b1, 8'h0B, 8'h00, rsp, ok);
    chk("vol read handshake", ok, 1);
    chk("vol read rsp_data", rsp, 8'h5A);
    extra = 0;
    repeat (150) begin @(negedge clk); if (rsp_valid) extra++; end
    chk("vol read single rsp", extra, 0);
    ovr_en = 1'b0;

    // randomized host traffic against the register-level reference
    for (int i = 0; i < 16; i++) begin
      rd = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      exp = rd ? ref_regs[a] : 8'h00;
      host_cmd(rd, a, d, rsp, ok);
      chk($sformatf("rand%0d handshake", i), ok, 1);
      chk($sformatf("rand%0d rsp rd=%0d a=%0h", i, rd, a), rsp, exp);
      if (!rd) ref_regs[a] = d;
    end

    // CSN never falls: timeout from ISSUE entry
    model_en = 1'b0;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (spi_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("timeout ready rise", ok, 1);
    n = 0;
    while (!error && n < TO + 50) begin @(negedge clk); n++; end
    chk("timeout latency", n, TO);
    chk("timeout error", error, 1);
    chk("timeout spi_ready", spi_ready, 0);
    chk("timeout busy", busy, 0);
    chk("timeout init_done", init_done, 0);

    // start from ERR restarts at entry 0
    model_en = 1'b1;
    base = fr_cnt; gv0 = gap_viol;
    pulse_start();
    chk("restart clears error", error, 0);
    chk("restart busy", busy, 1);
    finish_init_checks(base, gv0, "restart");

    // reset in the middle of a frame (second init frame, CSN low, ready dropped)
    base = fr_cnt;
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fr_cnt == base + 2 && !spi_csn && !spi_ready) begin ok = 1'b1; break; end
    end
    chk("midframe reached", ok, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midframe reset");
    rst = 1'b0;
    @(negedge clk);
    base = fr_cnt; gv0 = gap_viol;
    pulse_start();
    finish_init_checks(base, gv0, "after reset");

`ifdef VS_SCI_READBACK_CHECK_EN
    ovr_en = 1'b1; ovr_addr = 8'h03; ovr_val = 8'h99;
    base = fr_cnt;
    pulse_start();
    wait_flags(6000, ok);
    chk("readback flags in budget", ok, 1);
    chk("readback error", error, 1);
    chk("readback init_done", init_done, 0);
    chk("readback frames", fr_cnt - base, 4);
    ovr_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
